// File: rtl/rle_row_compressor_if.sv
// Row handshake bundle for rle_row_compressor: row input, packed/raw result output, busy status.
interface rle_row_compressor_if #(
    parameter int ROW_SIZE = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [ROW_SIZE-1:0] in_row;
    logic                out_valid;
    logic                out_ready;
    logic [ROW_SIZE-1:0] out_data;
    logic                out_raw;
    logic                busy;

    modport master (
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_data, out_raw, busy
    );

    modport slave (
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_data, out_raw, busy
    );
endinterface

// File: rtl/rle_row_compressor.sv
// Serial MSB-first run-length encoder for one binary row; unencodable rows pass through raw.
// Optional macro RLE_FAST_ZERO_EN: an all-zero row skips the scan and is emitted one cycle after accept.
module rle_row_compressor #(
    parameter int SECTION_SIZE = 4,
    parameter int ROW_SIZE     = 16
) (
    input logic              clk,
    input logic              rst,
    rle_row_compressor_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for a row, in_ready high
    // SCAN  | consuming one row bit per cycle, MSB first
    // EMIT  | result presented, held until out_ready
    localparam int NUM_SECTIONS = ROW_SIZE / SECTION_SIZE;
    localparam int MAX_RUN      = (1 << SECTION_SIZE) - 1;
    localparam int LEN_W        = SECTION_SIZE + 1;
    localparam int SEC_W        = $clog2(NUM_SECTIONS + 1);
    localparam int CNT_W        = $clog2(ROW_SIZE + 1);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT} stateT;

    stateT               state, stateNxt;
    logic [ROW_SIZE-1:0] shiftReg, shiftRegNxt;
    logic [ROW_SIZE-1:0] accum, accumNxt;
    logic                runBit, runBitNxt;
    logic [LEN_W-1:0]    runLen, runLenNxt;
    logic [SEC_W-1:0]    section, sectionNxt;
    logic                ovf, ovfNxt;
    logic [CNT_W-1:0]    bitCnt, bitCntNxt;
    logic [ROW_SIZE-1:0] outData, outDataNxt;
    logic                outRaw, outRawNxt;
    logic                curBit;
    logic                zeroRow;

    function automatic logic [ROW_SIZE-1:0] commitRun(
        input logic [ROW_SIZE-1:0] acc,
        input logic [SEC_W-1:0]    sec,
        input logic [LEN_W-1:0]    len
    );
        logic [ROW_SIZE-1:0] res;
        res = acc;
        for (int k = 0; k < NUM_SECTIONS; k++) begin
            if (sec == SEC_W'(k)) res[k*SECTION_SIZE +: SECTION_SIZE] = len[SECTION_SIZE-1:0];
        end
        return res;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shiftReg <= '0;
            accum    <= '0;
            runBit   <= 1'b0;
            runLen   <= '0;
            section  <= '0;
            ovf      <= 1'b0;
            bitCnt   <= '0;
            outData  <= '0;
            outRaw   <= 1'b0;
        end else begin
            state    <= stateNxt;
            shiftReg <= shiftRegNxt;
            accum    <= accumNxt;
            runBit   <= runBitNxt;
            runLen   <= runLenNxt;
            section  <= sectionNxt;
            ovf      <= ovfNxt;
            bitCnt   <= bitCntNxt;
            outData  <= outDataNxt;
            outRaw   <= outRawNxt;
        end
    end

    always_comb begin
        stateNxt    = state;
        shiftRegNxt = shiftReg;
        accumNxt    = accum;
        runBitNxt   = runBit;
        runLenNxt   = runLen;
        sectionNxt  = section;
        ovfNxt      = ovf;
        bitCntNxt   = bitCnt;
        outDataNxt  = outData;
        outRawNxt   = outRaw;
        curBit      = shiftReg[ROW_SIZE-1];
        zeroRow     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    shiftRegNxt = bus.in_row;
                    accumNxt    = '0;
                    runBitNxt   = 1'b0;
                    runLenNxt   = '0;
                    sectionNxt  = '0;
                    ovfNxt      = 1'b0;
                    bitCntNxt   = CNT_W'(ROW_SIZE);
                    stateNxt    = SCAN;
`ifdef RLE_FAST_ZERO_EN
                    if (bus.in_row == '0) begin
                        outDataNxt = '0;
                        outRawNxt  = 1'b0;
                        stateNxt   = EMIT;
                    end
`endif
                end
            end
            SCAN: begin
                // Rotating instead of shifting restores the original row after the last bit,
                // which is exactly what the raw pass-through needs.
                shiftRegNxt = {shiftReg[ROW_SIZE-2:0], curBit};
                bitCntNxt   = bitCnt - CNT_W'(1);
                if (curBit == runBit) begin
                    runLenNxt = runLen + LEN_W'(1);
                    if (runLenNxt > LEN_W'(MAX_RUN)) ovfNxt = 1'b1;
                end else begin
                    accumNxt = commitRun(accum, section, runLen);
                    if (section == SEC_W'(NUM_SECTIONS)) ovfNxt = 1'b1;
                    sectionNxt = (section == SEC_W'(NUM_SECTIONS)) ? section : section + SEC_W'(1);
                    runBitNxt  = ~runBit;
                    runLenNxt  = LEN_W'(1);
                end
                if (bitCnt == CNT_W'(1)) begin
                    accumNxt = commitRun(accumNxt, sectionNxt, runLenNxt);
                    if (sectionNxt == SEC_W'(NUM_SECTIONS)) ovfNxt = 1'b1;
                    // A full-width zero run overflows the field but encodes as all zeros.
                    zeroRow    = (shiftRegNxt == '0);
                    outRawNxt  = ovfNxt & ~zeroRow;
                    outDataNxt = outRawNxt ? shiftRegNxt : accumNxt;
                    stateNxt   = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) stateNxt = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == EMIT);
    assign bus.busy      = (state != IDLE);
    assign bus.out_data  = outData;
    assign bus.out_raw   = outRaw;
endmodule

// File: tb/tb_rle_row_compressor.sv
// Scoreboard bench for rle_row_compressor: directed rows, latency, throughput, backpressure, mid-scan reset.
module tb_rle_row_compressor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   lastAccept = 0;
    logic prevValid = 1'b0;

`ifdef RLE_FAST_ZERO_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 17;
`endif

    typedef struct {
        logic [15:0] data;
        logic        raw;
        int          lat;
        int          acc;
        int          tag;
    } expT;

    expT sb[$];

    rle_row_compressor_if #(.ROW_SIZE(16)) bus ();

    rle_row_compressor #(.SECTION_SIZE(4), .ROW_SIZE(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: latency when out_valid rises, payload on each transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && !prevValid) begin
                if (sb.size() == 0) check("unexpected_output", 32'(bus.out_data), 32'hDEAD);
                else check($sformatf("latency_row%0d", sb[0].tag), 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
            end
            if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
                check($sformatf("data_row%0d", sb[0].tag), 32'(bus.out_data), 32'(sb[0].data));
                check($sformatf("raw_row%0d", sb[0].tag), 32'(bus.out_raw), 32'(sb[0].raw));
                void'(sb.pop_front());
            end
        end
        prevValid <= bus.out_valid;
    end

    // Called and returns at posedge+1.
    task automatic sendRow(input logic [15:0] row, input logic [15:0] expData, input logic expRaw,
                           input int expLat, input int tag, input bit expectOut);
        bit  accepted;
        expT e;
        accepted     = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_row   = row;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                lastAccept = cyc;
                if (expectOut) begin
                    e.data = expData; e.raw = expRaw; e.lat = expLat; e.acc = cyc; e.tag = tag;
                    sb.push_back(e);
                end
                accepted = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!accepted) check($sformatf("accept_timeout_row%0d", tag), 32'd0, 32'd1);
    endtask

    task automatic waitIdle(input int tag);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && bus.in_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check($sformatf("drain_timeout_%0d", tag), 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  firstAcc;
        bit  seen;
        bus.in_valid  = 1'b0;
        bus.in_row    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_raw", 32'(bus.out_raw), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        sendRow(16'h0007, 16'h003D, 1'b0, 17, 1, 1'b1);
        waitIdle(1);

        sendRow(16'hC000, 16'h0E20, 1'b0, 17, 2, 1'b1);
        firstAcc = lastAccept;
        sendRow(16'h00F0, 16'h0448, 1'b0, 17, 3, 1'b1);
        check("throughput", 32'(lastAccept - firstAcc), 32'd18);
        waitIdle(3);

        sendRow(16'h0000, 16'h0000, 1'b0, ZERO_LAT, 4, 1'b1);
        waitIdle(4);
        sendRow(16'hAAAA, 16'hAAAA, 1'b1, 17, 5, 1'b1);
        sendRow(16'hFFFF, 16'hFFFF, 1'b1, 17, 6, 1'b1);
        sendRow(16'h0001, 16'h001F, 1'b0, 17, 7, 1'b1);
        waitIdle(7);

        // Backpressure: hold EMIT, offer a row that must be ignored.
        bus.out_ready = 1'b0;
        sendRow(16'h00F0, 16'h0448, 1'b0, 17, 8, 1'b1);
        seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("bp_valid_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_row   = 16'h1234;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            check("bp_data_hold", 32'(bus.out_data), 32'h0448);
            check("bp_raw_hold", 32'(bus.out_raw), 32'd0);
            check("bp_valid_hold", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
        check("bp_valid_after", 32'(bus.out_valid), 32'd0);
        waitIdle(8);

        // Abort mid-scan; the aborted row must never appear.
        sendRow(16'h0007, 16'h0000, 1'b0, 17, 9, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_out_data", 32'(bus.out_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sendRow(16'h0007, 16'h003D, 1'b0, 17, 10, 1'b1);
        waitIdle(10);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rle_row_compressor.md
Name: rle_row_compressor

Overview:
- Upstream stage of the row decompressor in the DCNN weight/feature path.
- Accepts one uncompressed binary row and scans it serially, MSB first.
- Emits the packed run-length word that the decompressor consumes: 4-bit run lengths, alternating 0-runs and 1-runs, first run at the LSB section.
- Rows that cannot be encoded are passed through raw with a flag so the downstream stage can bypass decompression.

Parameters:
- SECTION_SIZE, 4, width of one run-length field; max encodable run = 2^SECTION_SIZE-1.
- ROW_SIZE, 16, row width in bits; must be an integer multiple of SECTION_SIZE.
- NUM_SECTIONS (derived localparam = ROW_SIZE/SECTION_SIZE), 4, number of run fields per word.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_row valid.
- in_ready  out  1  block can accept a row (high only in IDLE).
- in_row  in  ROW_SIZE  uncompressed row; bit ROW_SIZE-1 is the first bit in run order.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.
- out_data  out  ROW_SIZE  compressed word, or raw row when out_raw=1.
- out_raw  out  1  1 = encoding overflowed, out_data is in_row verbatim.
- busy  out  1  high in SCAN or EMIT.

Behaviour:
- Reset (async): state=IDLE; in_ready=1; out_valid=0; out_data=0; out_raw=0; busy=0; internal run counter, section index and shift register cleared.
- Encoding: section k (bits k*SECTION_SIZE+:SECTION_SIZE) = length of the k-th run, scanning from the MSB. Run 0 is always a 0-run and may have length 0 (row starts with 1). Runs alternate 0/1. Unused upper sections = 0. The trailing run is always emitted, including a trailing 0-run.
- Special case: an all-zero row gives out_data=0, out_raw=0.
- Overflow triggers out_raw=1 and out_data=latched row. Conditions:
  - any run longer than 2^SECTION_SIZE-1, other than the all-zero case;
  - a required run index >= NUM_SECTIONS.
  - The overflow flag is sticky for the rest of the scan.
- FSM:
  - IDLE: in_valid&in_ready latches in_row → SCAN. Clear the accumulator, set run bit = 0, run length = 0, section = 0.
  - SCAN: one bit per cycle, ROW_SIZE cycles. Bit equal to current run bit: increment run length. Otherwise: commit the run length to the current section, advance the section, toggle the run bit, set run length = 1. After the last bit: commit the final run → EMIT.
  - EMIT: out_valid=1, out_data/out_raw stable. out_valid&out_ready → IDLE (in_ready high next cycle).
- Latency: accept at cycle 0 → out_valid at cycle ROW_SIZE+1 (17 by default), independent of content.
- Throughput: one row per ROW_SIZE+2 cycles with out_ready tied high.
- No input accepted while busy; in_valid is ignored outside IDLE.
- Backpressure: EMIT holds indefinitely; outputs must not change while out_valid&!out_ready.
- Width rules: the run counter is SECTION_SIZE+1 bits wide so a run of 16 is detected without wrap. The section index saturates at NUM_SECTIONS and flags overflow instead of wrapping.
- Reset mid-SCAN or mid-EMIT: abort immediately, drop the result; no partial output is ever presented.

Optional Feature:
- RLE_FAST_ZERO_EN defined: an accepted all-zero row bypasses SCAN. The FSM goes IDLE→EMIT, out_valid appears at cycle 1 with out_data=0, out_raw=0.
- RLE_FAST_ZERO_EN undefined: all rows take the full ROW_SIZE+1 latency.
- Encoded results are identical either way.

Test Plan:
- in_row=0x0007 → out_data=0x003D (runs 13,3), out_raw=0, out_valid exactly 17 cycles after the handshake.
- in_row=0xC000 → out_data=0x0E20 (runs 0,2,14), out_raw=0. Then in_row=0x00F0 → out_data=0x0448 (runs 8,4,4).
- in_row=0x0000 → out_data=0x0000, out_raw=0. Latency 17 without RLE_FAST_ZERO_EN, 1 with it.
- Overflow cases:
  - in_row=0xAAAA (16 runs) → out_raw=1, out_data=0xAAAA.
  - in_row=0xFFFF (run 0,16) → out_raw=1, out_data=0xFFFF.
  - in_row=0x0001 → out_data=0x001F, out_raw=0.
- Backpressure: hold out_ready=0 for 5 cycles in EMIT → out_data/out_raw stable, in_ready=0, a new in_valid is ignored. out_ready=1 → in_ready=1 next cycle.
- Assert rst at SCAN cycle 8 → out_valid=0, in_ready=1 immediately. After release, the next row encodes correctly with no stale runs (0x0007 → 0x003D).
